// File: rtl/sm_dvfs_pkg.sv
// Shared types and constants for the per-SM DVFS sequencer.
package sm_dvfs_pkg;

  localparam int unsigned CntWidth = 16;

  typedef logic [1:0] level_t;

  typedef enum logic [2:0] {
    StIdle,
    StVUp,
    StFSw,
    StVDown,
    StDwell
  } state_e;

  localparam logic [7:0] VidDefault0 = 8'h40;
  localparam logic [7:0] VidDefault1 = 8'h50;
  localparam logic [7:0] VidDefault2 = 8'h60;
  localparam logic [7:0] VidDefault3 = 8'h70;

  // Load value that makes a state last exactly `cycles` clock cycles.
  function automatic logic [CntWidth-1:0] cnt_load(input int unsigned cycles);
    return CntWidth'(cycles - 1);
  endfunction

endpackage

// File: rtl/sm_dvfs_sequencer_if.sv
// Signal bundle between the SM controller / clock-regulator side and the sequencer.
interface sm_dvfs_sequencer_if;
  import sm_dvfs_pkg::*;

  level_t     dvfs_req;
  logic       pll_lock;
  logic [7:0] vid;
  level_t     freq_sel;
  logic       pll_relock;
  logic       sm_stall;
  level_t     cur_level;
  logic       busy;
  logic       lock_fault;

  modport master (
    input  dvfs_req, pll_lock,
    output vid, freq_sel, pll_relock, sm_stall, cur_level, busy, lock_fault
  );

  modport slave (
    output dvfs_req, pll_lock,
    input  vid, freq_sel, pll_relock, sm_stall, cur_level, busy, lock_fault
  );

endinterface

// File: rtl/dvfs_countdown.sv
// Loadable down-counter shared by all timed states; saturates at zero.
module dvfs_countdown
  import sm_dvfs_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [CntWidth-1:0] i_load_val,
  input  logic                i_dec,
  output logic                o_zero
);

  logic [CntWidth-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sm_dvfs_sequencer.sv
// Per-SM DVFS sequencer: moves one level per pass, raising voltage before frequency
// on the way up and lowering it after frequency on the way down.
module sm_dvfs_sequencer
  import sm_dvfs_pkg::*;
#(
  parameter int unsigned RAMP_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT = 255,
  parameter int unsigned DWELL_CYCLES = 128,
  parameter logic [7:0]  VID0         = VidDefault0,
  parameter logic [7:0]  VID1         = VidDefault1,
  parameter logic [7:0]  VID2         = VidDefault2,
  parameter logic [7:0]  VID3         = VidDefault3
) (
  input logic                 clk,
  input logic                 rst_n,
  sm_dvfs_sequencer_if.master bus
);

  localparam logic [3:0][7:0]      VidTab    = {VID3, VID2, VID1, VID0};
  localparam logic [CntWidth-1:0] RampLoad  = cnt_load(RAMP_CYCLES);
  localparam logic [CntWidth-1:0] LockLoad  = cnt_load(LOCK_TIMEOUT);
  localparam logic [CntWidth-1:0] DwellLoad = cnt_load(DWELL_CYCLES);

  state_e     r_state;
  level_t     r_nxt;
  logic       r_dir_up;
  logic [7:0] r_vid;
  level_t     r_freq_sel;
  logic       r_pll_relock;
  logic       r_sm_stall;
  level_t     r_cur_level;
  logic       r_busy;
  logic       r_lock_fault;

  logic                w_zero;
  logic                w_go_up;
  logic                w_go_down;
  logic                w_lock_seen;
  level_t              w_lvl_up;
  level_t              w_lvl_dn;
  logic                w_load;
  logic                w_dec;
  logic [CntWidth-1:0] w_load_val;

  always_comb begin
    w_lvl_up    = r_cur_level + level_t'(1);
    w_lvl_dn    = r_cur_level - level_t'(1);
    w_go_up     = (bus.dvfs_req > r_cur_level) && !r_lock_fault;
    w_go_down   = (bus.dvfs_req < r_cur_level);
    // The lock input is stale while the relock pulse is still out.
    w_lock_seen = !r_pll_relock && bus.pll_lock;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_dec       = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_go_up) begin
          w_load     = 1'b1;
          w_load_val = RampLoad;
        end else if (w_go_down) begin
          w_load     = 1'b1;
          w_load_val = LockLoad;
        end
      end
      StVUp: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = LockLoad;
        end else begin
          w_dec = 1'b1;
        end
      end
      StFSw: begin
        if (w_lock_seen) begin
          w_load     = 1'b1;
          w_load_val = r_dir_up ? DwellLoad : RampLoad;
        end else if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = DwellLoad;
        end else begin
          w_dec = 1'b1;
        end
      end
      StVDown: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = DwellLoad;
        end else begin
          w_dec = 1'b1;
        end
      end
      StDwell: w_dec = 1'b1;
      default: ;
    endcase
  end

  dvfs_countdown u_countdown (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_nxt        <= '0;
      r_dir_up     <= 1'b0;
      r_vid        <= VID0;
      r_freq_sel   <= '0;
      r_pll_relock <= 1'b0;
      r_sm_stall   <= 1'b0;
      r_cur_level  <= '0;
      r_busy       <= 1'b0;
      r_lock_fault <= 1'b0;
    end else begin
      r_pll_relock <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_go_up) begin
            r_nxt    <= w_lvl_up;
            r_dir_up <= 1'b1;
            r_vid    <= VidTab[w_lvl_up];
            r_busy   <= 1'b1;
            r_state  <= StVUp;
          end else if (w_go_down) begin
            r_nxt        <= w_lvl_dn;
            r_dir_up     <= 1'b0;
            r_freq_sel   <= w_lvl_dn;
            r_sm_stall   <= 1'b1;
            r_pll_relock <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= StFSw;
          end
        end
        StVUp: begin
          if (w_zero) begin
            r_freq_sel   <= r_nxt;
            r_sm_stall   <= 1'b1;
            r_pll_relock <= 1'b1;
            r_state      <= StFSw;
          end
        end
        StFSw: begin
          if (w_lock_seen) begin
            r_sm_stall  <= 1'b0;
            r_cur_level <= r_nxt;
            if (r_dir_up) begin
              r_state <= StDwell;
            end else begin
              r_vid   <= VidTab[r_nxt];
              r_state <= StVDown;
            end
          end else if (w_zero) begin
            // Fall back to the previous PLL setting without another relock.
            r_lock_fault <= 1'b1;
            r_freq_sel   <= r_cur_level;
            r_vid        <= VidTab[r_cur_level];
            r_sm_stall   <= 1'b0;
            r_state      <= StDwell;
          end
        end
        StVDown: begin
          if (w_zero) r_state <= StDwell;
        end
        StDwell: begin
          if (w_zero) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.vid        = r_vid;
  assign bus.freq_sel   = r_freq_sel;
  assign bus.pll_relock = r_pll_relock;
  assign bus.sm_stall   = r_sm_stall;
  assign bus.cur_level  = r_cur_level;
  assign bus.busy       = r_busy;
  assign bus.lock_fault = r_lock_fault;

endmodule
